// File: rtl/int_fetch_unit_if.sv
// int_fetch_unit_if: bus bundle between the fetch unit and its environment
//   pc         CPU program counter           (master -> slave)
//   ir1        registered instruction word   (slave -> master)
//   prog_we/prog_addr/prog_data  instruction store write port (master -> slave)
//   mask_we/mask_in              interrupt mask load          (master -> slave)
//   irq        interrupt requests, bit 0 highest priority      (master -> slave)
//   int_ack    one-hot acknowledge of the taken irq            (slave -> master)
//   in_service high while an interrupt handler runs            (slave -> master)
//   ret_pc     saved return address                            (slave -> master)
interface int_fetch_unit_if;
   logic [0:3]  pc;
   logic [0:15] ir1;
   logic        prog_we;
   logic [0:3]  prog_addr;
   logic [0:15] prog_data;
   logic        mask_we;
   logic [3:0]  mask_in;
   logic [3:0]  irq;
   logic [3:0]  int_ack;
   logic        in_service;
   logic [0:3]  ret_pc;
   modport master (output pc, prog_we, prog_addr, prog_data, mask_we, mask_in, irq,
                   input  ir1, int_ack, in_service, ret_pc);
   modport slave  (input  pc, prog_we, prog_addr, prog_data, mask_we, mask_in, irq,
                   output ir1, int_ack, in_service, ret_pc);
endinterface

// File: rtl/int_fetch_unit.sv
// int_fetch_unit: 16x16 instruction store feeding the CPU ir1 bus, with
// single-level vectored interrupts injected as JMP words at pc boundaries.
//   clk  rising-edge clock
//   rst  asynchronous active-low reset (instruction store is not reset)
//   bus  int_fetch_unit_if.slave: pc, ir1, prog write port, mask load,
//        irq, int_ack, in_service, ret_pc
// Build option: define IRQ_EDGE_EN for edge-triggered, latched requests;
// otherwise requests are level-sensitive.
module int_fetch_unit #(
   parameter logic [3:0]  VEC_BASE  = 4'd12,
   parameter logic [15:0] RETI_WORD = 16'h7000
) (
   input logic clk,
   input logic rst,
   int_fetch_unit_if.slave bus
);
   typedef enum logic [1:0] {RUN, VEC, RET} state_t;
   state_t      state;
   logic [0:15] mem [16];
   logic [0:3]  pc_q;
   logic [3:0]  mask, pending, req, ack_d, vec;
   logic [1:0]  idx;
   logic [0:15] word;
   logic        bnd, take, ret;
   always_ff @(posedge clk)
      if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
   assign word  = mem[bus.pc];
   // a jump to its own address leaves pc unchanged, so self-loops never see a boundary
   assign bnd   = bus.pc != pc_q;
   assign req   = pending & mask;
   assign idx   = req[0] ? 2'd0 : req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd3;
   assign vec   = VEC_BASE + {2'b00, idx};
   assign take  = bnd && !bus.in_service && req != 4'b0;
   assign ret   = bnd && bus.in_service && word == RETI_WORD;
   assign ack_d = take ? 4'b0001 << idx : 4'b0000;
`ifdef IRQ_EDGE_EN
   logic [3:0] irq_q, pend_q;
   // a new edge in the ack cycle wins over the clear
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         irq_q  <= '0;
         pend_q <= '0;
      end else begin
         irq_q  <= bus.irq;
         pend_q <= (pend_q & ~ack_d) | (bus.irq & ~irq_q);
      end
   assign pending = pend_q;
`else
   assign pending = bus.irq;
`endif
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state          <= RUN;
         pc_q           <= '0;
         mask           <= '0;
         bus.ir1        <= '0;
         bus.int_ack    <= '0;
         bus.in_service <= 1'b0;
         bus.ret_pc     <= '0;
      end else begin
         pc_q        <= bus.pc;
         bus.int_ack <= ack_d;
         if (bus.mask_we) mask <= bus.mask_in;
         if (take) begin
            bus.ir1        <= {4'hA, 4'h0, vec, 4'h0};
            bus.ret_pc     <= bus.pc;
            bus.in_service <= 1'b1;
            state          <= VEC;
         end else if (ret) begin
            bus.ir1        <= {4'hA, 4'h0, bus.ret_pc, 4'h0};
            bus.in_service <= 1'b0;
            state          <= RET;
         end else if (bnd || state == RUN) begin
            // RUN tracks store writes every clk; VEC/RET hold the injected word until pc moves
            bus.ir1 <= word;
            state   <= RUN;
         end
      end
endmodule

// File: tb/tb_int_fetch_unit.sv
// tb_int_fetch_unit: scoreboard bench for int_fetch_unit (level or IRQ_EDGE_EN build)
module tb_int_fetch_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int_fetch_unit_if bus ();
   int_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      string       tag;
      logic [15:0] ir1;
      logic [3:0]  ack;
      logic        sv;
      logic [3:0]  ret;
   } exp_t;
   exp_t sb[$];
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic expect_out(input string tag, input logic [15:0] e_ir, input logic [3:0] e_ack,
                             input logic e_sv, input logic [3:0] e_ret);
      exp_t e;
      e.tag = tag;
      e.ir1 = e_ir;
      e.ack = e_ack;
      e.sv  = e_sv;
      e.ret = e_ret;
      sb.push_back(e);
   endtask
   task automatic compare();
      exp_t e;
      e = sb.pop_front();
      check({e.tag, ".ir1"}, bus.ir1, e.ir1);
      check({e.tag, ".ack"}, {12'h0, bus.int_ack}, {12'h0, e.ack});
      check({e.tag, ".svc"}, {15'h0, bus.in_service}, {15'h0, e.sv});
      check({e.tag, ".ret"}, {12'h0, bus.ret_pc}, {12'h0, e.ret});
   endtask
   task automatic step(input string tag, input logic [3:0] p, input logic [15:0] e_ir,
                       input logic [3:0] e_ack, input logic e_sv, input logic [3:0] e_ret);
      bus.pc = p;
      expect_out(tag, e_ir, e_ack, e_sv, e_ret);
      @(posedge clk);
      #1;
      compare();
   endtask
   task automatic set_mask(input logic [3:0] m);
      bus.mask_we = 1'b1;
      bus.mask_in = m;
      @(posedge clk);
      #1;
      bus.mask_we = 1'b0;
   endtask
   initial begin
      bus.pc = '0;
      bus.prog_we = 1'b0;
      bus.prog_addr = '0;
      bus.prog_data = '0;
      bus.mask_we = 1'b0;
      bus.mask_in = '0;
      bus.irq = '0;
      #2 rst = 1'b0;
      #1;
      expect_out("reset", 16'h0, 4'h0, 1'b0, 4'h0);
      compare();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus.prog_we   = 1'b1;
         bus.prog_addr = i[3:0];
         bus.prog_data = (i == 1) ? 16'h2105 : (i == 9) ? 16'h7000 : 16'h2000 + i[15:0];
         @(posedge clk);
         #1;
      end
      bus.prog_we = 1'b0;
      step("t1", 1, 16'h2105, 4'h0, 0, 0);
      step("run2", 2, 16'h2002, 4'h0, 0, 0);
      set_mask(4'hF);
      step("run3", 3, 16'h2003, 4'h0, 0, 0);
      bus.irq = 4'b0100;
      step("idle3", 3, 16'h2003, 4'h0, 0, 0);
      step("vec2", 4, 16'hA0E0, 4'b0100, 1, 4);
      bus.irq = 4'b0000;
      step("hold", 4, 16'hA0E0, 4'h0, 1, 4);
      step("isr", 5, 16'h2005, 4'h0, 1, 4);
      step("reti", 9, 16'hA040, 4'h0, 0, 4);
      step("back", 5, 16'h2005, 4'h0, 0, 4);
      bus.irq = 4'b1001;
      step("idle5", 5, 16'h2005, 4'h0, 0, 4);
      step("prio", 6, 16'hA0C0, 4'b0001, 1, 6);
      bus.irq = 4'b0000;
      step("reti2", 9, 16'hA060, 4'h0, 0, 6);
`ifdef IRQ_EDGE_EN
      step("pend3", 6, 16'hA0F0, 4'b1000, 1, 6);
      step("reti3", 9, 16'hA060, 4'h0, 0, 6);
`else
      step("run6", 6, 16'h2006, 4'h0, 0, 6);
      step("pass", 9, 16'h7000, 4'h0, 0, 6);
`endif
      step("run7", 7, 16'h2007, 4'h0, 0, 6);
      bus.irq = 4'b0010;
      step("idle7", 7, 16'h2007, 4'h0, 0, 6);
      step("vec1", 8, 16'hA0D0, 4'b0010, 1, 8);
      step("reti4", 9, 16'hA080, 4'h0, 0, 8);
`ifdef IRQ_EDGE_EN
      step("noreent", 8, 16'h2008, 4'h0, 0, 8);
      step("pass2", 9, 16'h7000, 4'h0, 0, 8);
`else
      step("reenter", 8, 16'hA0D0, 4'b0010, 1, 8);
      step("reti5", 9, 16'hA080, 4'h0, 0, 8);
`endif
      bus.irq = 4'b1000;
      set_mask(4'b0111);
      step("masked", 2, 16'h2002, 4'h0, 0, 8);
      set_mask(4'hF);
      step("vec3", 3, 16'hA0F0, 4'b1000, 1, 3);
      bus.irq = 4'b0000;
      step("reti6", 9, 16'hA030, 4'h0, 0, 3);
      bus.irq = 4'b0001;
      step("idle9", 9, 16'hA030, 4'h0, 0, 3);
      step("vec0", 4, 16'hA0C0, 4'b0001, 1, 4);
      rst = 1'b0;
      #1;
      expect_out("arst", 16'h0, 4'h0, 0, 0);
      compare();
      @(negedge clk);
      rst = 1'b1;
      step("rel", 4, 16'h2004, 4'h0, 0, 0);
      step("nomask", 5, 16'h2005, 4'h0, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
